// File: rtl/fft16_pkg.sv
// Shared types and constants for the 16-point frame scheduler: Q7 twiddles,
// bit-reverse helper, FSM states and butterfly addressing.
package fft16_pkg;

  localparam int N_PTS = 16;
  localparam int TW_W  = 9;

  // W16^k in Q7, k = 0..7 (128 = 1.0)
  localparam logic signed [TW_W-1:0] TW_RE [8] = '{
    9'sd128, 9'sd118, 9'sd90, 9'sd49, 9'sd0, -9'sd49, -9'sd90, -9'sd118
  };
  localparam logic signed [TW_W-1:0] TW_IM [8] = '{
    9'sd0, -9'sd49, -9'sd90, -9'sd118, -9'sd128, -9'sd118, -9'sd90, -9'sd49
  };

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_e;

  // One butterfly request: two bank addresses and the twiddle index
  typedef struct packed {
    logic [3:0] top;
    logic [3:0] bot;
    logic [2:0] k;
  } bfly_addr_t;

  function automatic logic [3:0] bitrev4(input logic [3:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

  function automatic bfly_addr_t bfly_addr(input logic [1:0] s, input logic [2:0] b);
    bfly_addr_t a;
    logic [3:0] half;
    logic [3:0] pos;
    logic [3:0] grp;
    half  = 4'd1 << s;
    pos   = {1'b0, b} & (half - 4'd1);
    grp   = ({1'b0, b} >> s) << ({1'b0, s} + 3'd1);
    a.top = grp + pos;
    a.bot = a.top + half;
    a.k   = 3'(pos << (2'd3 - s));
    return a;
  endfunction

endpackage

// File: rtl/fft16_bfly2.sv
// Combinational radix-2 DIT butterfly with Q7 twiddle: top/bot' = (top*128 +/- bot*W) >>> 7,
// computed at DATA_W+9 bits and wrapped back to DATA_W.
module fft16_bfly2
  import fft16_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] i_top_re,
  input  logic signed [DATA_W-1:0] i_top_im,
  input  logic signed [DATA_W-1:0] i_bot_re,
  input  logic signed [DATA_W-1:0] i_bot_im,
  input  logic signed [TW_W-1:0]   i_tw_re,
  input  logic signed [TW_W-1:0]   i_tw_im,
  output logic signed [DATA_W-1:0] o_top_re,
  output logic signed [DATA_W-1:0] o_top_im,
  output logic signed [DATA_W-1:0] o_bot_re,
  output logic signed [DATA_W-1:0] o_bot_im
);

  localparam int PW = DATA_W + 9;

  logic signed [PW-1:0] w_br, w_bi, w_wr, w_wi;
  logic signed [PW-1:0] w_ar, w_ai;
  logic signed [PW-1:0] w_t_re, w_t_im;
  logic signed [PW-1:0] w_sp_re, w_sp_im, w_sm_re, w_sm_im;
  logic                 w_unused;

  always_comb begin
    w_br    = PW'(i_bot_re);
    w_bi    = PW'(i_bot_im);
    w_wr    = PW'(i_tw_re);
    w_wi    = PW'(i_tw_im);
    w_ar    = PW'(i_top_re) <<< 7;
    w_ai    = PW'(i_top_im) <<< 7;
    w_t_re  = w_br * w_wr - w_bi * w_wi;
    w_t_im  = w_br * w_wi + w_bi * w_wr;
    w_sp_re = w_ar + w_t_re;
    w_sp_im = w_ai + w_t_im;
    w_sm_re = w_ar - w_t_re;
    w_sm_im = w_ai - w_t_im;
  end

  // Taking bits [DATA_W+6:7] is the floor shift by 7 followed by the DATA_W wrap
  assign o_top_re = w_sp_re[DATA_W+6:7];
  assign o_top_im = w_sp_im[DATA_W+6:7];
  assign o_bot_re = w_sm_re[DATA_W+6:7];
  assign o_bot_im = w_sm_im[DATA_W+6:7];

  assign w_unused = ^{w_sp_re[6:0], w_sp_re[PW-1:DATA_W+7],
                      w_sp_im[6:0], w_sp_im[PW-1:DATA_W+7],
                      w_sm_re[6:0], w_sm_re[PW-1:DATA_W+7],
                      w_sm_im[6:0], w_sm_im[PW-1:DATA_W+7]};

endmodule

// File: rtl/fft16_frame_sched.sv
// 16-point DIT FFT frame scheduler: loads a frame bit-reversed, runs 32 in-place
// butterflies on one shared fft16_bfly2, then streams bins out in natural order.
module fft16_frame_sched
  import fft16_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_in_re,
  input  logic [DATA_W-1:0] i_in_im,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic [DATA_W-1:0] o_out_re,
  output logic [DATA_W-1:0] o_out_im,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_last,
  output logic              o_busy
);

  state_e     r_state, w_state_nxt;
  logic [3:0] r_cnt;
  logic [1:0] r_stage;
  logic [2:0] r_bfly;
  logic       w_in_acc, w_out_hs, w_last_bfly;

  logic [N_PTS-1:0][DATA_W-1:0] r_bank_re, r_bank_im;

  bfly_addr_t                w_ba;
  logic signed [DATA_W-1:0]  w_top_re, w_top_im, w_bot_re, w_bot_im;

  assign w_ba        = bfly_addr(r_stage, r_bfly);
  assign w_last_bfly = (r_stage == 2'd3) && (r_bfly == 3'd7);

  fft16_bfly2 #(.DATA_W(DATA_W)) u_bfly (
    .i_top_re (r_bank_re[w_ba.top]),
    .i_top_im (r_bank_im[w_ba.top]),
    .i_bot_re (r_bank_re[w_ba.bot]),
    .i_bot_im (r_bank_im[w_ba.bot]),
    .i_tw_re  (TW_RE[w_ba.k]),
    .i_tw_im  (TW_IM[w_ba.k]),
    .o_top_re (w_top_re),
    .o_top_im (w_top_im),
    .o_bot_re (w_bot_re),
    .o_bot_im (w_bot_im)
  );

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b0;
    w_in_acc    = 1'b0;
    w_out_hs    = 1'b0;
    case (r_state)
      LOAD: begin
        o_in_ready = 1'b1;
        w_in_acc   = i_in_valid;
        if (w_in_acc && (r_cnt == 4'd15)) w_state_nxt = COMPUTE;
      end
      COMPUTE: begin
        o_busy = 1'b1;
        if (w_last_bfly) w_state_nxt = UNLOAD;
      end
      UNLOAD: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
        w_out_hs    = i_out_ready;
        if (w_out_hs && (r_cnt == 4'd15)) w_state_nxt = LOAD;
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  // r_cnt is the load index in LOAD and the bin index in UNLOAD; it wraps to 0 at each frame end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= LOAD;
      r_cnt   <= '0;
      r_stage <= '0;
      r_bfly  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_in_acc || w_out_hs) r_cnt <= r_cnt + 4'd1;
      if (r_state == COMPUTE) begin
        r_bfly <= r_bfly + 3'd1;
        if (r_bfly == 3'd7) r_stage <= r_stage + 2'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_in_acc) begin
      r_bank_re[bitrev4(r_cnt)] <= i_in_re;
      r_bank_im[bitrev4(r_cnt)] <= i_in_im;
    end else if (r_state == COMPUTE) begin
      r_bank_re[w_ba.top] <= w_top_re;
      r_bank_im[w_ba.top] <= w_top_im;
      r_bank_re[w_ba.bot] <= w_bot_re;
      r_bank_im[w_ba.bot] <= w_bot_im;
    end
  end

  assign o_out_re   = r_bank_re[r_cnt];
  assign o_out_im   = r_bank_im[r_cnt];
  assign o_out_last = (r_state == UNLOAD) && (r_cnt == 4'd15);

endmodule

// File: tb/tb_fft16_frame_sched.sv
// Directed bench for fft16_frame_sched: expected bins are queued when a frame is
// sent and popped as bins stream out.
module tb_fft16_frame_sched;

  localparam int DATA_W = 32;

  typedef struct {
    longint re;
    longint im;
    longint tol;
  } exp_t;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic [DATA_W-1:0] i_in_re = '0;
  logic [DATA_W-1:0] i_in_im = '0;
  logic              i_in_valid = 1'b0;
  logic              o_in_ready;
  logic [DATA_W-1:0] o_out_re, o_out_im;
  logic              o_out_valid;
  logic              i_out_ready = 1'b1;
  logic              o_out_last;
  logic              o_busy;

  fft16_frame_sched #(.DATA_W(DATA_W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_in_re     (i_in_re),
    .i_in_im     (i_in_im),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .o_out_re    (o_out_re),
    .o_out_im    (o_out_im),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_last  (o_out_last),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int     checks = 0;
  int     failures = 0;
  exp_t   sb[$];
  longint xr[16], xi[16], mr[16], mi[16];
  longint twr[8] = '{128, 118, 90, 49, 0, -49, -90, -118};
  longint twi[8] = '{0, -49, -90, -118, -128, -118, -90, -49};
  int     acc_first, acc_last, hs_last, first_ov;

  task automatic chk(input string tag, input longint obs, input longint exp, input longint tol);
    longint d;
    checks++;
    d = obs - exp;
    assert ((tol == 0) ? (obs === exp) : (d <= tol && d >= -tol))
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
    end
  endtask

  function automatic longint wrapn(input longint v, input int n);
    return (v <<< (64 - n)) >>> (64 - n);
  endfunction

  // Reference FFT: bit-reversed load, then per stage walk groups of 2*h with twiddle step 8/h
  task automatic run_model();
    longint ar[16], ai[16];
    for (int n = 0; n < 16; n++) begin
      int r;
      r = ((n & 1) << 3) | ((n & 2) << 1) | ((n & 4) >> 1) | ((n & 8) >> 3);
      ar[r] = xr[n];
      ai[r] = xi[n];
    end
    for (int s = 0; s < 4; s++) begin
      int h;
      h = 1 << s;
      for (int g = 0; g < 16; g += 2 * h) begin
        for (int j = 0; j < h; j++) begin
          int t, u, k;
          longint tr, ti, pr, pi;
          t  = g + j;
          u  = t + h;
          k  = j * (8 / h);
          tr = wrapn(ar[u] * twr[k] - ai[u] * twi[k], DATA_W + 9);
          ti = wrapn(ar[u] * twi[k] + ai[u] * twr[k], DATA_W + 9);
          pr = ar[t] * 128;
          pi = ai[t] * 128;
          ar[t] = wrapn(wrapn(pr + tr, DATA_W + 9) >>> 7, DATA_W);
          ai[t] = wrapn(wrapn(pi + ti, DATA_W + 9) >>> 7, DATA_W);
          ar[u] = wrapn(wrapn(pr - tr, DATA_W + 9) >>> 7, DATA_W);
          ai[u] = wrapn(wrapn(pi - ti, DATA_W + 9) >>> 7, DATA_W);
        end
      end
    end
    for (int n = 0; n < 16; n++) begin
      mr[n] = ar[n];
      mi[n] = ai[n];
    end
  endtask

  task automatic push_exp(input longint re, input longint im, input longint tol);
    exp_t e;
    e.re = re; e.im = im; e.tol = tol;
    sb.push_back(e);
  endtask

  task automatic push_model();
    run_model();
    for (int n = 0; n < 16; n++) push_exp(mr[n], mi[n], 0);
  endtask

  task automatic clear_x();
    for (int n = 0; n < 16; n++) begin
      xr[n] = 0;
      xi[n] = 0;
    end
  endtask

  task automatic send_frame();
    for (int n = 0; n < 16; n++) begin
      bit rdy;
      int w;
      i_in_valid = 1'b1;
      i_in_re    = DATA_W'(xr[n]);
      i_in_im    = DATA_W'(xi[n]);
      rdy = 1'b0;
      w   = 0;
      while (!rdy && w < 200) begin
        @(negedge i_clk);
        rdy = o_in_ready;
        @(posedge i_clk); #1;
        w++;
      end
      if (!rdy) chk("accept_timeout", 0, 1, 0);
      if (n == 0) acc_first = cyc;
    end
    acc_last   = cyc;
    i_in_valid = 1'b0;
  endtask

  task automatic recv_frame(input int stall_at, input int stall_len);
    int   got, stalled, guard;
    bit   seen;
    exp_t e;
    got = 0; stalled = 0; guard = 0; seen = 0;
    while (got < 16 && guard < 400) begin
      i_out_ready = !(got == stall_at && stalled < stall_len);
      @(negedge i_clk);
      if (o_out_valid && !seen) begin
        seen     = 1;
        first_ov = cyc;
      end
      if (o_out_valid) begin
        if (sb.size() == 0) begin
          chk("scoreboard_underflow", 0, 1, 0);
          got = 16;
        end else if (i_out_ready) begin
          e = sb.pop_front();
          chk($sformatf("bin%0d_re", got), $signed(o_out_re), e.re, e.tol);
          chk($sformatf("bin%0d_im", got), $signed(o_out_im), e.im, e.tol);
          chk($sformatf("bin%0d_last", got), o_out_last, (got == 15), 0);
          got++;
        end else begin
          e = sb[0];
          chk($sformatf("stall_bin%0d_re", got), $signed(o_out_re), e.re, e.tol);
          chk($sformatf("stall_bin%0d_im", got), $signed(o_out_im), e.im, e.tol);
          stalled++;
        end
      end
      @(posedge i_clk); #1;
      guard++;
    end
    hs_last     = cyc;
    i_out_ready = 1'b1;
    chk("bins_received", got, 16, 0);
  endtask

  task automatic post_frame_idle();
    @(negedge i_clk);
    chk("post_out_valid", o_out_valid, 0, 0);
    chk("post_in_ready", o_in_ready, 1, 0);
    chk("post_busy", o_busy, 0, 0);
    @(posedge i_clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    chk("rst_in_ready", o_in_ready, 1, 0);
    chk("rst_out_valid", o_out_valid, 0, 0);
    chk("rst_out_last", o_out_last, 0, 0);
    chk("rst_busy", o_busy, 0, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // Impulse at x[0]: flat spectrum, plus first-output latency
    clear_x();
    xr[0] = 1000;
    for (int k = 0; k < 16; k++) push_exp(1000, 0, 0);
    send_frame();
    @(negedge i_clk);
    chk("busy_in_compute", o_busy, 1, 0);
    chk("in_ready_in_compute", o_in_ready, 0, 0);
    @(posedge i_clk); #1;
    recv_frame(-1, 0);
    chk("latency_impulse", first_ov - acc_last, 32, 0);
    post_frame_idle();

    // DC with a 5-cycle stall on bin 3
    clear_x();
    for (int n = 0; n < 16; n++) xr[n] = 100;
    push_exp(1600, 0, 0);
    for (int k = 1; k < 16; k++) push_exp(0, 0, 0);
    send_frame();
    recv_frame(3, 5);
    chk("latency_dc", first_ov - acc_last, 32, 0);
    chk("sb_empty_dc", sb.size(), 0, 0);
    post_frame_idle();

    // Reset in the middle of COMPUTE, then a clean impulse frame
    clear_x();
    xr[0] = 1000;
    send_frame();
    repeat (9) begin
      @(posedge i_clk); #1;
    end
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("midrst_in_ready", o_in_ready, 1, 0);
    chk("midrst_out_valid", o_out_valid, 0, 0);
    chk("midrst_busy", o_busy, 0, 0);
    @(posedge i_clk); #1;
    sb.delete();
    for (int k = 0; k < 16; k++) push_exp(1000, 0, 0);
    send_frame();
    recv_frame(-1, 0);
    post_frame_idle();

    // Shifted impulse x[1]=128 -> bin k = 128*W16^k, then a back-to-back random frame
    clear_x();
    xr[1] = 128;
    for (int k = 0; k < 16; k++) begin
      if (k < 8) push_exp(twr[k], twi[k], 2);
      else       push_exp(-twr[k-8], -twi[k-8], 2);
    end
    send_frame();
    recv_frame(-1, 0);
    for (int n = 0; n < 16; n++) begin
      xr[n] = longint'($urandom_range(0, 2097152)) - 1048576;
      xi[n] = longint'($urandom_range(0, 2097152)) - 1048576;
    end
    push_model();
    send_frame();
    chk("b2b_first_accept", acc_first - hs_last, 1, 0);
    recv_frame(7, 2);
    post_frame_idle();

    // Overflow: 16 * 2^(DATA_W-5) wraps bin 0
    for (int n = 0; n < 16; n++) begin
      xr[n] = longint'(1) << (DATA_W - 5);
      xi[n] = 0;
    end
    push_model();
    send_frame();
    recv_frame(-1, 0);
    chk("sb_empty_end", sb.size(), 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
